// File: rtl/gate_bist_ctrl.sv
// ============================================================================
// gate_bist_ctrl : self-test sequencer for a single 2-input combinational gate
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] tt_exp,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [1:0] ff_q, ff_d;
  logic       w_mismatch;

  assign w_mismatch = (gate_y != tt_q[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fv_q    <= 1'b0;
      ff_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d    = tt_exp;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          fv_d    = 1'b0;
          ff_d    = 2'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (w_mismatch) begin
          err_d = err_q + 3'd1;
          // Only the earliest failing vector is recorded.
          if (!fv_q) begin
            ff_d = vec_q;
            fv_d = 1'b1;
          end
        end
        if (vec_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 3'd0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gate_a     = vec_q[1];
  assign gate_b     = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
// ============================================================================
// tb_gate_bist_ctrl : table-driven bench with result scoreboard
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_bist_ctrl;

  typedef struct {
    int lat;
    int pass;
    int err;
    int fv;
    int ff;
  } exp_t;

  typedef struct {
    int         sel;
    logic [2:0] mode;
    logic [3:0] tt;
    exp_t       e;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] tt_exp = 4'b0000;
  logic [2:0] mode   = 3'd0;

  // Index 0: SETTLE_CYCLES=2, 1: SETTLE_CYCLES=1, 2: SETTLE_CYCLES=3
  logic       ga   [3];
  logic       gb   [3];
  logic       gy   [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic       fv   [3];
  logic [2:0] errc [3];
  logic [1:0] ff   [3];
  logic [1:0] dly1 = 2'b00;
  logic [1:0] dly3 = 2'b00;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [2:0] m, input logic a, input logic b);
    case (m)
      3'd0:    return ~(a ^ b);
      3'd1:    return 1'b0;
      3'd2:    return a & b;
      3'd3:    return 1'b1;
      default: return a ^ b;
    endcase
  endfunction

  assign gy[0] = gate_fn(mode, ga[0], gb[0]);

  // XNOR gates whose outputs lag their inputs by two clocks
  always @(posedge clk) begin
    dly1 <= {dly1[0], ~(ga[1] ^ gb[1])};
    dly3 <= {dly3[0], ~(ga[2] ^ gb[2])};
  end
  assign gy[1] = dly1[1];
  assign gy[2] = dly3[1];

  gate_bist_ctrl #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_exp(tt_exp), .gate_y(gy[0]),
    .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .fail_valid(fv[0]), .first_fail(ff[0])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_exp(tt_exp), .gate_y(gy[1]),
    .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .fail_valid(fv[1]), .first_fail(ff[1])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .tt_exp(tt_exp), .gate_y(gy[2]),
    .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(errc[2]), .fail_valid(fv[2]), .first_fail(ff[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int lat, input int p, input int e, input int v, input int f);
    exp_t r;
    r.lat  = lat;
    r.pass = p;
    r.err  = e;
    r.fv   = v;
    r.ff   = f;
    return r;
  endfunction

  function automatic vec_t mk(input int sel, input logic [2:0] m, input logic [3:0] tt,
                              input int lat, input int p, input int e, input int v, input int f);
    vec_t r;
    r.sel  = sel;
    r.mode = m;
    r.tt   = tt;
    r.e    = mk_exp(lat, p, e, v, f);
    return r;
  endfunction

  // Waits for done on the selected instance, counting edges from the accept edge,
  // then pops the pending expectation and compares.
  task automatic run_score(input int sel, input int pulse_at, input bit hold, input bit chk_seq);
    exp_t e;
    bit   got = 1'b0;
    int   lat = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (pulse_at == k) begin
        start  = 1'b1;
        tt_exp = 4'b0110;
      end else if (!hold) begin
        start = 1'b0;
      end
      tick();
      if (k == 1) begin
        check("busy_after_start", busy[sel], 1);
        check("pass_cleared", pass[sel], 0);
        check("err_cleared", errc[sel], 0);
      end
      if (chk_seq && k < 12) check("vector_seq", {ga[sel], gb[sel]}, k / 3);
      if (done[sel]) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    if (!got) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("done_latency", lat, e.lat);
    check("pass", pass[sel], e.pass);
    check("err_count", errc[sel], e.err);
    check("fail_valid", fv[sel], e.fv);
    check("first_fail", ff[sel], e.ff);
    check("busy_at_done", busy[sel], 0);
  endtask

  initial begin
    tbl.push_back(mk(0, 3'd0, 4'b1001, 13, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd1, 4'b1001, 13, 0, 2, 1, 0));
    tbl.push_back(mk(0, 3'd2, 4'b1001, 13, 0, 1, 1, 0));
    tbl.push_back(mk(0, 3'd2, 4'b1000, 13, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 4'b0110, 13, 0, 4, 1, 0));
    tbl.push_back(mk(0, 3'd3, 4'b1001, 13, 0, 2, 1, 1));
    tbl.push_back(mk(0, 3'd4, 4'b0100, 13, 0, 1, 1, 1));
    tbl.push_back(mk(0, 3'd2, 4'b1100, 13, 0, 1, 1, 2));
    tbl.push_back(mk(0, 3'd2, 4'b0000, 13, 0, 1, 1, 3));
    tbl.push_back(mk(1, 3'd0, 4'b1001,  9, 0, 2, 1, 1));
    tbl.push_back(mk(2, 3'd0, 4'b1001, 17, 1, 0, 0, 0));

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_gate_a", ga[0], 0);
    check("rst_gate_b", gb[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_pass", pass[0], 0);
    check("rst_err_count", errc[0], 0);
    check("rst_fail_valid", fv[0], 0);
    check("rst_first_fail", ff[0], 0);
    rst_n = 1'b1;
    repeat (2) tick();

    foreach (tbl[i]) begin
      mode   = tbl[i].mode;
      tt_exp = tbl[i].tt;
      sbq.push_back(tbl[i].e);
      start = 1'b1;
      tick();
      run_score(tbl[i].sel, 0, 1'b0, i == 0);
      repeat (10) tick();
      check("hold_pass", pass[tbl[i].sel], tbl[i].e.pass);
      check("hold_err_count", errc[tbl[i].sel], tbl[i].e.err);
      check("hold_first_fail", ff[tbl[i].sel], tbl[i].e.ff);
    end

    // start pulse and truth-table change mid-run must not disturb the run
    mode   = 3'd0;
    tt_exp = 4'b1001;
    sbq.push_back(mk_exp(13, 1, 0, 0, 0));
    start = 1'b1;
    tick();
    run_score(0, 5, 1'b0, 1'b0);
    repeat (10) tick();

    // start held high: second run accepted on the edge after done
    tt_exp = 4'b1001;
    sbq.push_back(mk_exp(13, 1, 0, 0, 0));
    sbq.push_back(mk_exp(14, 1, 0, 0, 0));
    start = 1'b1;
    tick();
    run_score(0, 0, 1'b1, 1'b0);
    run_score(0, 0, 1'b1, 1'b0);
    start = 1'b0;
    repeat (10) tick();

    // asynchronous reset during SETTLE of vector 2'b10
    mode   = 3'd1;
    tt_exp = 4'b1001;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_rst_vector", {ga[0], gb[0]}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gate_a", ga[0], 0);
    check("async_rst_gate_b", gb[0], 0);
    check("async_rst_busy", busy[0], 0);
    check("async_rst_pass", pass[0], 0);
    check("async_rst_err_count", errc[0], 0);
    check("async_rst_fail_valid", fv[0], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    mode = 3'd0;
    sbq.push_back(mk_exp(13, 1, 0, 0, 0));
    start = 1'b1;
    tick();
    run_score(0, 0, 1'b0, 1'b1);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
